// File: rtl/fetch_pkg.sv
// fetch_pkg: shared amode constants, instruction length decode and FSM
// state encoding for instr_prefetch.
// Build option AMODE_CHECK_EN: amode 1xx decodes as a 16-bit illegal
// instruction (flagged on o_error); otherwise it decodes as 48-bit.
package fetch_pkg;

    localparam logic [2:0] AMODE16 = 3'b000;
    localparam logic [2:0] AMODE32 = 3'b001;
    // 010 and 011 both select 48-bit; only the upper two bits are compared
    localparam logic [2:0] AMODE48 = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } fetch_state_t;

    // Instruction length in halfwords from the head halfword's low three bits
    function automatic logic [1:0] amode_len(input logic [2:0] amode);
        logic [1:0] len;
        if (amode == AMODE16) begin
            len = 2'd1;
        end else if (amode == AMODE32) begin
            len = 2'd2;
        end else if (amode[2:1] == AMODE48[2:1]) begin
            len = 2'd3;
        end else begin
`ifdef AMODE_CHECK_EN
            len = 2'd1;
`else
            len = 2'd3;
`endif
        end
        return len;
    endfunction

endpackage

// File: rtl/hw_fifo.sv
// hw_fifo: circular halfword buffer. Accepts 0-2 halfwords and releases
// 0-3 halfwords per cycle; exposes the three head halfwords, occupancy and
// free count. Flush empties it in one cycle and overrides push/pop.
module hw_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_flush,
    input  logic [1:0]             i_push_cnt,
    input  logic [15:0]            i_push_hw0,
    input  logic [15:0]            i_push_hw1,
    input  logic [1:0]             i_pop_cnt,
    output logic [15:0]            o_hw0,
    output logic [15:0]            o_hw1,
    output logic [15:0]            o_hw2,
    output logic [$clog2(DEPTH):0] o_occ,
    output logic [$clog2(DEPTH):0] o_free
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [AW-1:0] wr_idx1, rd_idx1, rd_idx2;

    // Pointers wrap naturally because DEPTH is a power of two
    assign wr_idx1 = wr_ptr_q + AW'(1);
    assign rd_idx1 = rd_ptr_q + AW'(1);
    assign rd_idx2 = rd_ptr_q + AW'(2);

    assign o_hw0  = mem_q[rd_ptr_q];
    assign o_hw1  = mem_q[rd_idx1];
    assign o_hw2  = mem_q[rd_idx2];
    assign o_occ  = occ_q;
    assign o_free = CW'(DEPTH) - occ_q;

    // Next pointer/occupancy: flush resets, otherwise advance by push and pop
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(i_pop_cnt);
            wr_ptr_d = wr_ptr_q + AW'(i_push_cnt);
            occ_d    = occ_q + CW'(i_push_cnt) - CW'(i_pop_cnt);
        end
    end

    // Control registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage write; slots were reserved at issue so a push never overruns
    always_ff @(posedge i_clk) begin
        if (!i_flush) begin
            if (i_push_cnt != 2'd0) mem_q[wr_ptr_q] <= i_push_hw0;
            if (i_push_cnt == 2'd2) mem_q[wr_idx1]  <= i_push_hw1;
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: Wishbone instruction prefetcher. Keeps a halfword buffer
// filled from sequential word fetches and presents one 16/32/48-bit
// instruction per cycle with its PC. Redirect flushes and restarts.
// Build option AMODE_CHECK_EN: flag amode 1xx as illegal on o_error.
module instr_prefetch
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter int                 DEPTH    = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic              o_wb_cyc,
    output logic [3:0]        o_wb_stb,
    output logic              o_wb_we,
    output logic [31:0]       o_wb_dat,
    input  logic [31:0]       i_wb_dat,
    input  logic              i_wb_ack,
    input  logic              i_wb_err,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [ADDR_W-1:0] o_pc,
    output logic [47:0]       o_instruction,
    output logic [1:0]        o_len,
    output logic              o_valid,
    input  logic              i_consume,
    output logic              o_error
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] HW_MASK = ~ADDR_W'(1);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cyc_q, cyc_d;
    logic [3:0]        stb_q, stb_d;
    logic              unal_q, unal_d;

    logic [15:0]   hw0, hw1, hw2;
    logic [CW-1:0] occ, free;
    logic [1:0]    head_len, need, push_cnt, pop_cnt;
    logic          head_complete, do_pop, ack_ok, err_visible;
    logic          unused_bits;

    assign unused_bits = fetch_pc_q[0];

    hw_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_flush    (i_redirect),
        .i_push_cnt (push_cnt),
        .i_push_hw0 (unal_q ? i_wb_dat[15:0] : i_wb_dat[31:16]),
        .i_push_hw1 (i_wb_dat[15:0]),
        .i_pop_cnt  (pop_cnt),
        .o_hw0      (hw0),
        .o_hw1      (hw1),
        .o_hw2      (hw2),
        .o_occ      (occ),
        .o_free     (free)
    );

    assign head_len      = amode_len(hw0[2:0]);
    assign head_complete = occ >= CW'(head_len);
    assign o_valid       = head_complete && !i_redirect;
    assign do_pop        = o_valid && i_consume;
    assign pop_cnt       = do_pop ? head_len : 2'd0;
    // Ack data arriving in a redirect cycle belongs to the abandoned stream
    assign ack_ok        = (state_q == REQ) && i_wb_ack && !i_redirect;
    assign push_cnt      = ack_ok ? (unal_q ? 2'd1 : 2'd2) : 2'd0;
    // Only one request is ever outstanding, so in IDLE nothing is reserved
    assign need          = fetch_pc_q[1] ? 2'd1 : 2'd2;
    assign err_visible   = (state_q == ERR) && !head_complete;

    assign o_len     = head_len;
    assign o_pc      = pc_q;
    assign o_wb_addr = addr_q;
    assign o_wb_cyc  = cyc_q;
    assign o_wb_stb  = stb_q;
    assign o_wb_we   = 1'b0;
    assign o_wb_dat  = 32'h0;
`ifdef AMODE_CHECK_EN
    assign o_error   = err_visible || (o_valid && hw0[2]);
`else
    assign o_error   = err_visible;
`endif

    // Left-align the head instruction and zero-pad below its length
    always_comb begin
        o_instruction = {hw0, 32'h0};
        case (head_len)
            2'd2:    o_instruction = {hw0, hw1, 16'h0};
            2'd3:    o_instruction = {hw0, hw1, hw2};
            default: ;
        endcase
    end

    // Fetch FSM next state; redirect overrides every other transition
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        unal_d     = unal_q;
        if (do_pop) pc_d = pc_q + ADDR_W'({head_len, 1'b0});
        if (i_redirect) begin
            state_d    = IDLE;
            fetch_pc_d = i_pc & HW_MASK;
            pc_d       = i_pc & HW_MASK;
            cyc_d      = 1'b0;
            stb_d      = 4'b0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (free >= CW'(need)) begin
                        state_d = REQ;
                        cyc_d   = 1'b1;
                        stb_d   = fetch_pc_q[1] ? 4'b0011 : 4'b1111;
                        addr_d  = {fetch_pc_q[ADDR_W-1:2], 2'b00};
                        unal_d  = fetch_pc_q[1];
                    end
                end
                REQ: begin
                    if (i_wb_ack) begin
                        state_d    = IDLE;
                        cyc_d      = 1'b0;
                        stb_d      = 4'b0000;
                        fetch_pc_d = {fetch_pc_q[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00};
                    end else if (i_wb_err) begin
                        state_d = ERR;
                        cyc_d   = 1'b0;
                        stb_d   = 4'b0000;
                    end
                end
                ERR:     ;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM and bus output registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC & HW_MASK;
            pc_q       <= RESET_PC & HW_MASK;
            addr_q     <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 4'b0000;
            unal_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            unal_q     <= unal_d;
        end
    end

endmodule
